// File: rtl/mips_fetch_queue_if.sv
// Bus and handshake bundle between the fetch queue, instruction memory,
// the branch/halt control and the decode stage.
interface mips_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // instruction memory read port
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  // control-flow inputs
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt_req;
  // decode handshake
  logic              id_valid;
  logic [31:0]       id_ir;
  logic [31:0]       id_npc;
  logic              id_ready;
  logic [CNT_W-1:0]  fq_count;

  // fetch queue side
  modport master (
    output mem_rd_en, mem_addr, id_valid, id_ir, id_npc, fq_count,
    input  mem_rdata, redirect_valid, redirect_pc, halt_req, id_ready
  );

  // environment side: memory, branch unit and decode
  modport slave (
    input  mem_rd_en, mem_addr, id_valid, id_ir, id_npc, fq_count,
    output mem_rdata, redirect_valid, redirect_pc, halt_req, id_ready
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// MIPS32 instruction prefetch queue: issues word reads to a synchronous
// instruction memory, buffers {instruction, next-PC} pairs in a small FIFO
// and presents the head to decode with show-ahead valid/ready. Taken-branch
// redirects flush buffered and in-flight fetches; halt stops new fetches.
module mips_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                 clk1,
  input  logic                 rst,
  mips_fetch_queue_if.master   fq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] rec_addr_r;
  logic              inflight_r;
  logic              kill_r;
  logic              halted_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [31:0]       fifo_ir_r  [DEPTH];
  logic [ADDR_W-1:0] fifo_npc_r [DEPTH];

  logic [ADDR_W-1:0] mem_addr_s;
  logic [ADDR_W-1:0] npc_addr_s;
  logic [CNT_W:0]    occ_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              unused_s;

  // only the low ADDR_W bits of the branch target address the memory
  assign unused_s = ^fq.redirect_pc[31:ADDR_W];

  // issue/push/pop decisions and the fetch address mux
  always_comb begin
    occ_s      = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    npc_addr_s = rec_addr_r + ADDR_W'(1);
    mem_addr_s = pc_r;
    issue_s    = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;

    if (fq.redirect_valid) begin
      mem_addr_s = fq.redirect_pc[ADDR_W-1:0];
    end else begin
      mem_addr_s = pc_r;
    end

    // occupancy counts the read in flight but not a same-cycle pop, so the
    // FIFO can never overflow; a redirect fetches regardless because the
    // FIFO and the in-flight read are being discarded in the same cycle
    if (!rst && !halted_r && !fq.halt_req && (fq.redirect_valid || (occ_s < DEPTH_OCC))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end

    // a response is dropped on redirect, after a kill, or around reset
    if (inflight_r && !kill_r && !fq.redirect_valid && !rst) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    if ((count_r != '0) && fq.id_ready && !fq.redirect_valid) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign fq.mem_rd_en = issue_s;
  assign fq.mem_addr  = mem_addr_s;
  assign fq.id_valid  = (count_r != '0);
  assign fq.id_ir     = fifo_ir_r[rd_ptr_r];
  assign fq.id_npc    = {{(32 - ADDR_W){1'b0}}, fifo_npc_r[rd_ptr_r]};
  assign fq.fq_count  = count_r;

  // fetch PC, in-flight tracking, halt latch and FIFO occupancy/pointers
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_r       <= '0;
      rec_addr_r <= '0;
      inflight_r <= 1'b0;
      kill_r     <= 1'b0;
      halted_r   <= 1'b0;
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
    end else begin
      halted_r   <= halted_r | fq.halt_req;
      inflight_r <= issue_s;
      if (issue_s) begin
        rec_addr_r <= mem_addr_s;
        pc_r       <= mem_addr_s + ADDR_W'(1);
      end
      // a redirect that could not refetch (halted) leaves nothing valid
      // behind; kill guards the following response slot for one cycle
      kill_r <= fq.redirect_valid && inflight_r && !issue_s;

      if (fq.redirect_valid) begin
        count_r  <= '0;
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // FIFO storage: returned word plus the sequential next-PC of its address
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_ir_r[i]  <= 32'h0000_0000;
        fifo_npc_r[i] <= '0;
      end
    end else if (push_s) begin
      fifo_ir_r[wr_ptr_r]  <= fq.mem_rdata;
      fifo_npc_r[wr_ptr_r] <= npc_addr_s;
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Scoreboard bench for mips_fetch_queue: expected {ir, npc} pairs are queued
// when a fetch stream is started and compared as decode accepts entries.
module tb_mips_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] sb_q[$];

  mips_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) fq_if ();

  mips_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .fq   (fq_if)
  );

  always #5 clk1 = ~clk1;

  // synchronous instruction memory: mem[i] = 0x1000_0000 + i
  always @(posedge clk1) begin
    if (fq_if.mem_rd_en) fq_if.mem_rdata <= 32'h1000_0000 + {22'd0, fq_if.mem_addr};
    else                 fq_if.mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // queue the expected sequential stream starting at word address start
  task automatic sb_push(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = 32'((start + i) % 1024);
      sb_q.push_back({32'h1000_0000 + a, 32'((a + 32'd1) % 32'd1024)});
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk1);
  endtask

  // two-cycle reset, then release with n entries of the stream from 0 expected
  task automatic do_reset(input logic ready, input int n);
    rst = 1'b1;
    sb_q.delete();
    fq_if.redirect_valid = 1'b0;
    fq_if.halt_req       = 1'b0;
    fq_if.id_ready       = ready;
    tick();
    tick();
    rst = 1'b0;
    sb_push(0, n);
  endtask

  // consumer: every accepted head must match the next expected entry
  always @(negedge clk1) begin
    if (!rst && fq_if.id_valid && fq_if.id_ready && !fq_if.redirect_valid) begin
      chk("sb_avail", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("pop_ir", fq_if.id_ir, e[63:32]);
        chk("pop_npc", fq_if.id_npc, e[31:0]);
      end
    end
  end

  initial begin
    fq_if.redirect_valid = 1'b0;
    fq_if.redirect_pc    = 32'd0;
    fq_if.halt_req       = 1'b0;
    fq_if.id_ready       = 1'b1;

    // reset state
    tick();
    to_neg();
    chk("rst_valid", 32'(fq_if.id_valid), 32'd0);
    chk("rst_ir", fq_if.id_ir, 32'd0);
    chk("rst_npc", fq_if.id_npc, 32'd0);
    chk("rst_count", 32'(fq_if.fq_count), 32'd0);
    chk("rst_rd", 32'(fq_if.mem_rd_en), 32'd0);

    // streaming from address 0: first entry two cycles after the first issue
    tick();
    rst = 1'b0;
    sb_push(0, 64);
    to_neg();
    chk("s_rd0", 32'(fq_if.mem_rd_en), 32'd1);
    chk("s_addr0", 32'(fq_if.mem_addr), 32'd0);
    tick(); to_neg();
    chk("s_valid_c1", 32'(fq_if.id_valid), 32'd0);
    tick(); to_neg();
    chk("s_valid_c2", 32'(fq_if.id_valid), 32'd1);
    chk("s_ir_c2", fq_if.id_ir, 32'h1000_0000);
    chk("s_npc_c2", fq_if.id_npc, 32'd1);
    repeat (10) tick();

    // backpressure: queue fills, fetch stops, head holds
    do_reset(1'b0, 64);
    repeat (6) tick();
    chk("bp_count", 32'(fq_if.fq_count), 32'd4);
    chk("bp_valid", 32'(fq_if.id_valid), 32'd1);
    chk("bp_ir", fq_if.id_ir, 32'h1000_0000);
    to_neg();
    chk("bp_rd", 32'(fq_if.mem_rd_en), 32'd0);
    tick();
    fq_if.id_ready = 1'b1;
    repeat (12) tick();

    // redirect with three buffered entries and one read in flight
    do_reset(1'b0, 0);
    repeat (4) tick();
    chk("rd_pre_cnt", 32'(fq_if.fq_count), 32'd3);
    fq_if.redirect_valid = 1'b1;
    fq_if.redirect_pc    = 32'h0000_0020;
    fq_if.id_ready       = 1'b1;
    sb_q.delete();
    sb_push(32'h20, 64);
    to_neg();
    chk("rd_rd", 32'(fq_if.mem_rd_en), 32'd1);
    chk("rd_addr", 32'(fq_if.mem_addr), 32'h20);
    tick();
    fq_if.redirect_valid = 1'b0;
    to_neg();
    chk("rd_flush", 32'(fq_if.id_valid), 32'd0);
    tick(); to_neg();
    chk("rd_valid", 32'(fq_if.id_valid), 32'd1);
    chk("rd_ir", fq_if.id_ir, 32'h1000_0020);
    chk("rd_npc", fq_if.id_npc, 32'h21);
    repeat (5) tick();

    // address wrap at the top of instruction memory
    fq_if.redirect_valid = 1'b1;
    fq_if.redirect_pc    = 32'd1022;
    sb_q.delete();
    sb_push(1022, 64);
    to_neg();
    chk("wr_addr0", 32'(fq_if.mem_addr), 32'd1022);
    tick();
    fq_if.redirect_valid = 1'b0;
    to_neg();
    chk("wr_addr1", 32'(fq_if.mem_addr), 32'd1023);
    tick(); to_neg();
    chk("wr_addr2", 32'(fq_if.mem_addr), 32'd0);
    repeat (6) tick();

    // halt at cycle 5: in-flight word (address 4) still delivered, then idle
    do_reset(1'b1, 5);
    repeat (5) tick();
    fq_if.halt_req = 1'b1;
    to_neg();
    chk("h_rd_c5", 32'(fq_if.mem_rd_en), 32'd0);
    tick();
    fq_if.halt_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      to_neg();
      chk("h_rd", 32'(fq_if.mem_rd_en), 32'd0);
      tick();
    end
    chk("h_valid", 32'(fq_if.id_valid), 32'd0);
    chk("h_count", 32'(fq_if.fq_count), 32'd0);
    chk("h_drain", 32'(sb_q.size()), 32'd0);
    fq_if.redirect_valid = 1'b1;
    fq_if.redirect_pc    = 32'h40;
    to_neg();
    chk("h_rd_redir", 32'(fq_if.mem_rd_en), 32'd0);
    tick();
    fq_if.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("h_valid_redir", 32'(fq_if.id_valid), 32'd0);
      tick();
    end

    // one-cycle reset mid-stream with a read in flight
    do_reset(1'b1, 64);
    repeat (6) tick();
    rst = 1'b1;
    sb_q.delete();
    to_neg();
    chk("mr_rd", 32'(fq_if.mem_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    sb_push(0, 64);
    chk("mr_count", 32'(fq_if.fq_count), 32'd0);
    chk("mr_valid", 32'(fq_if.id_valid), 32'd0);
    to_neg();
    chk("mr_rd1", 32'(fq_if.mem_rd_en), 32'd1);
    chk("mr_addr", 32'(fq_if.mem_addr), 32'd0);
    tick(); to_neg();
    chk("mr_valid_c1", 32'(fq_if.id_valid), 32'd0);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
